dds_sample_capture: RTL

// - Trigger-armed snapshot buffer for the parallel DDS/DUC sample bus that feeds the AD9739A port A/B mux.
// - Captures DEPTH frames of NUM_PH parallel samples per clk, then streams them back one sample per handshake
//   in time order (frame-major, phase 0 first) for a ChipScope/SPI-readback or bench checker.
// - Generalises the fixed 12-phase x 14-bit sample view to parametrised phase count, width and depth,

---
 rtl/dds_sample_capture.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dds_sample_capture.sv
// dds_sample_capture: arm/trigger snapshot of the parallel DDS sample bus, streamed back one sample per handshake.
// Optional feature: define DDS_CAP_OFFSET_BIN_EN to present readout samples in offset binary (MSB inverted).
module dds_sample_capture #(
    parameter int NUM_PH   = 12,
    parameter int SAMPLE_W = 14,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int PH_W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PH*SAMPLE_W-1:0]   din,
    input  logic                         din_valid,
    input  logic                         arm,
    input  logic                         trig,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [SAMPLE_W-1:0]          rd_data,
    output logic                         rd_last,
    output logic [1:0]                   state,
    output logic [ADDR_W:0]              cap_cnt
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;
    state_t                       state_q, state_d;
    logic [ADDR_W:0]              cap_cnt_q, cap_cnt_d;
    logic [ADDR_W-1:0]            fr_q, fr_d;
    logic [PH_W-1:0]              ph_q, ph_d;
    logic                         rd_valid_q, rd_valid_d;
    logic                         wr_en;
    logic [SAMPLE_W-1:0]          s;
    logic [NUM_PH*SAMPLE_W-1:0]   mem [DEPTH];
    logic [NUM_PH*SAMPLE_W-1:0]   frame_q;

    assign rd_last  = rd_valid_q && fr_q == ADDR_W'(DEPTH-1) && ph_q == PH_W'(NUM_PH-1);
    assign rd_valid = rd_valid_q;
    assign state    = state_q;
    assign cap_cnt  = cap_cnt_q;

    // Next-state, write enable and readout pointer advance; readout data is valid from the first READOUT cycle.
    always_comb begin
        state_d    = state_q;
        cap_cnt_d  = cap_cnt_q;
        fr_d       = fr_q;
        ph_d       = ph_q;
        rd_valid_d = rd_valid_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: state_d = arm ? ARMED : IDLE;
            ARMED: begin
                if (trig) begin
                    state_d   = CAPTURE;
                    wr_en     = din_valid;
                    cap_cnt_d = din_valid ? cap_cnt_q + 1'b1 : cap_cnt_q;
                end
            end
            CAPTURE: begin
                if (din_valid) begin
                    wr_en     = 1'b1;
                    cap_cnt_d = cap_cnt_q + 1'b1;
                    if (cap_cnt_q[ADDR_W-1:0] == ADDR_W'(DEPTH-1)) begin
                        state_d    = READOUT;
                        rd_valid_d = 1'b1;
                        fr_d       = '0;
                        ph_d       = '0;
                    end
                end
            end
            READOUT: begin
                if (rd_valid_q && rd_ready) begin
                    if (rd_last) begin
                        state_d    = IDLE;
                        rd_valid_d = 1'b0;
                        cap_cnt_d  = '0;
                        fr_d       = '0;
                        ph_d       = '0;
                    end else if (ph_q == PH_W'(NUM_PH-1)) begin
                        ph_d = '0;
                        fr_d = fr_q + 1'b1;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Control registers; any reset abandons the capture or readout in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cap_cnt_q  <= '0;
            fr_q       <= '0;
            ph_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_cnt_q  <= cap_cnt_d;
            fr_q       <= fr_d;
            ph_q       <= ph_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Frame RAM; reading at the next frame index keeps frame_q aligned with fr_q with no bubble.
    always_ff @(posedge clk) begin
        if (wr_en) mem[cap_cnt_q[ADDR_W-1:0]] <= din;
        frame_q <= mem[fr_d];
    end

    // Phase lane select out of the registered frame.
    always_comb begin
        s = '0;
        for (int i = 0; i < NUM_PH; i++)
            if (ph_q == PH_W'(i)) s = frame_q[i*SAMPLE_W +: SAMPLE_W];
    end

`ifdef DDS_CAP_OFFSET_BIN_EN
    assign rd_data = rd_valid_q ? {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]} : '0;
`else
    assign rd_data = rd_valid_q ? s : '0;
`endif
endmodule
